// File: rtl/tpsram_check_reader.sv
// rtl/tpsram_check_reader.sv - TPSRAM_C0 read-side pattern checker with restart request
module tpsram_check_reader #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8,
   parameter int DEPTH = 64,
   parameter logic [DATA_W-1:0] SEED = 8'hA5,
   parameter int RD_LATENCY = 1,
   parameter int ERR_THRESH = 1,
   parameter int RST_PULSE_CYC = 16
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_TPSRAM_RD_sv,
   output logic [ADDR_W-1:0] o_TPSRAM_RADDR_sv,
   output logic              o_TPSRAM_REN,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ADDR_W:0]   o_err_count,
   output logic [ADDR_W-1:0] o_first_err_addr,
   output logic              o_reset_n
);

   localparam int CW = $clog2(RST_PULSE_CYC) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] THRESH_C = (ADDR_W + 1)'(ERR_THRESH);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, REPORT, RST_REQ} state_t;

   state_t state, state_nx;
   logic [ADDR_W-1:0] raddr;
   logic [CW-1:0] cnt;
   logic tag_v [RD_LATENCY];
   logic [ADDR_W-1:0] tag_a [RD_LATENCY];
   logic [ADDR_W:0] err_count, err_next;
   logic [ADDR_W-1:0] first_err;
   logic pass_q;
   logic reset_n_q;
   logic start_acc;
   logic mism;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (i_start) state_nx = READ;
         READ:    if (raddr == LAST_ADDR) state_nx = DRAIN;
         DRAIN:   if (cnt == '0) state_nx = REPORT;
         REPORT:  state_nx = (err_count >= THRESH_C) ? RST_REQ : IDLE;
         RST_REQ: if (cnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The oldest tag lines up with the read data returning for that address.
   always_comb begin
      start_acc = (state == IDLE) && i_start;
      mism = tag_v[RD_LATENCY-1] &&
             (i_TPSRAM_RD_sv != (DATA_W'(tag_a[RD_LATENCY-1]) ^ SEED));
      err_next = err_count;
      if (mism && (err_count != DEPTH_C)) err_next = err_count + 1'b1;
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state <= IDLE;
         raddr <= '0;
         cnt <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_v[i] <= 1'b0;
            tag_a[i] <= '0;
         end
         err_count <= '0;
         first_err <= '0;
         pass_q <= 1'b0;
         reset_n_q <= 1'b1;
      end else begin
         state <= state_nx;
         tag_v[0] <= (state == READ);
         tag_a[0] <= raddr;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_a[i] <= tag_a[i-1];
         end

         if (start_acc) begin
            raddr <= '0;
            err_count <= '0;
            first_err <= '0;
            pass_q <= 1'b0;
         end else begin
            if (state == READ && raddr != LAST_ADDR) raddr <= raddr + 1'b1;
            err_count <= err_next;
            if (mism && err_count == '0) first_err <= tag_a[RD_LATENCY-1];
            // err_next includes the final compare that lands on this same edge.
            if (state == DRAIN && state_nx == REPORT) pass_q <= (err_next == '0);
         end

         if (state == READ && state_nx == DRAIN) cnt <= CW'(RD_LATENCY - 1);
         else if (state == REPORT && state_nx == RST_REQ) cnt <= CW'(RST_PULSE_CYC - 1);
         else if (cnt != '0) cnt <= cnt - 1'b1;

         reset_n_q <= (state_nx != RST_REQ);
      end
   end

   assign o_TPSRAM_RADDR_sv = raddr;
   assign o_TPSRAM_REN = (state == READ);
   assign o_busy = (state != IDLE);
   assign o_done = (state == REPORT);
   assign o_pass = pass_q;
   assign o_err_count = err_count;
   assign o_first_err_addr = first_err;
   assign o_reset_n = reset_n_q;

endmodule
